// File: rtl/fetch_ctrl_pkg.sv
// Shared widths, reset vector and state encoding for the instruction-fetch controller.
package fetch_ctrl_pkg;

  localparam int          CPU_WIDTH_DEF = 32;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;

  localparam logic [2:0] ST_BOOT = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_RESP = 3'd2;
  localparam logic [2:0] ST_HOLD = 3'd3;
  localparam logic [2:0] ST_HALT = 3'd4;

  typedef enum logic [2:0] {
    BOOT = ST_BOOT,
    REQ  = ST_REQ,
    RESP = ST_RESP,
    HOLD = ST_HOLD,
    HALT = ST_HALT
  } fetch_state_e;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_ctrl_pc_reg.sv
// Architectural fetch PC register; the next-PC selection lives in the parent.
module fetch_ctrl_pc_reg #(
  parameter int             W       = 32,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] pc_d_i,
  output logic [W-1:0] pc_q_o
);

  logic [W-1:0] pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RST_VAL;
    end else if (load_i) begin
      pc_q <= pc_d_i;
    end
  end

  assign pc_q_o = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: one outstanding imem request, redirect priority trap > branch > PC+4,
// and debug halt at quiescent points.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int                     CPU_WIDTH = CPU_WIDTH_DEF,
  parameter logic [CPU_WIDTH-1:0]   RESET_VEC = RESET_VEC_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 imem_req,
  output logic [CPU_WIDTH-1:0] imem_addr,
  input  logic                 imem_gnt,
  input  logic                 imem_rvalid,
  input  logic [31:0]          imem_rdata,
  output logic                 inst_valid,
  output logic [31:0]          inst,
  output logic [CPU_WIDTH-1:0] inst_pc,
  input  logic                 id_ready,
  input  logic                 redirect_valid,
  input  logic [CPU_WIDTH-1:0] redirect_pc,
  input  logic                 trap_valid,
  input  logic [CPU_WIDTH-1:0] trap_vec,
  input  logic                 halt_req,
  output logic                 halted,
  output logic                 misalign
);

  fetch_state_e         state_q, state_d;
  logic                 kill_q, kill_d;
  logic [31:0]          inst_q, inst_d;
  logic [CPU_WIDTH-1:0] inst_pc_q, inst_pc_d;
  logic                 misalign_q, misalign_d;
  logic [CPU_WIDTH-1:0] pc_q, pc_d;
  logic                 pc_ld;
  logic                 redir_en;
  logic [CPU_WIDTH-1:0] redir_tgt;

  fetch_ctrl_pc_reg #(
    .W       (CPU_WIDTH),
    .RST_VAL (RESET_VEC)
  ) u_pc_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (pc_ld),
    .pc_d_i (pc_d),
    .pc_q_o (pc_q)
  );

  assign redir_en  = (trap_valid || redirect_valid) && (state_q != BOOT);
  assign redir_tgt = trap_valid ? trap_vec : redirect_pc;

  always_comb begin
    state_d    = state_q;
    kill_d     = kill_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    misalign_d = 1'b0;
    pc_ld      = 1'b0;
    pc_d       = pc_q;

    if (redir_en) begin
      pc_ld      = 1'b1;
      pc_d       = {redir_tgt[CPU_WIDTH-1:2], 2'b00};
      misalign_d = is_misaligned(redir_tgt[1:0]);
    end

    case (state_q)
      BOOT: state_d = halt_req ? HALT : REQ;
      REQ: begin
        // A redirect racing the grant leaves a response in flight that must be discarded.
        if (imem_gnt) begin
          state_d = RESP;
          kill_d  = redir_en;
        end
      end
      RESP: begin
        if (imem_rvalid) begin
          if (kill_q || redir_en) begin
            kill_d  = 1'b0;
            state_d = (halt_req && !redir_en) ? HALT : REQ;
          end else begin
            inst_d    = imem_rdata;
            inst_pc_d = pc_q;
            state_d   = HOLD;
          end
        end else if (redir_en) begin
          kill_d = 1'b1;
        end
      end
      HOLD: begin
        if (redir_en) begin
          state_d = REQ;
        end else if (id_ready) begin
          pc_ld   = 1'b1;
          pc_d    = pc_q + CPU_WIDTH'(4);
          state_d = halt_req ? HALT : REQ;
        end
      end
      HALT: begin
        if (!halt_req) begin
          state_d = REQ;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      kill_q     <= 1'b0;
      inst_q     <= '0;
      inst_pc_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      kill_q     <= kill_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem_req   = (state_q == REQ);
  assign imem_addr  = pc_q;
  assign inst_valid = (state_q == HOLD);
  assign halted     = (state_q == HALT);
  assign misalign   = misalign_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;

endmodule
